// File: rtl/c17_bist_ctrl_if.sv
// c17_bist_ctrl_if: run control, DUT stimulus/response and result signals of the c17 BIST sequencer.
// Latency: none, this is wiring only.
// Backpressure: none. C17_BIST_FAILLOG_EN adds first_fail/first_fail_vld.
interface c17_bist_ctrl_if;
   logic       start;
   logic       resp_n22;
   logic       resp_n23;
   logic [4:0] vec;
   logic       busy;
   logic       done;
   logic       pass;
   logic [5:0] err_cnt;
   logic [7:0] signature;
`ifdef C17_BIST_FAILLOG_EN
   logic [4:0] first_fail;
   logic       first_fail_vld;
`endif

   // Requester side: issues start, drives the device-under-test responses, observes results.
   modport master (
      output start, resp_n22, resp_n23,
      input  vec, busy, done, pass, err_cnt, signature
`ifdef C17_BIST_FAILLOG_EN
      , input first_fail, first_fail_vld
`endif
   );

   // Sequencer side.
   modport slave (
      input  start, resp_n22, resp_n23,
      output vec, busy, done, pass, err_cnt, signature
`ifdef C17_BIST_FAILLOG_EN
      , output first_fail, first_fail_vld
`endif
   );
endinterface

// File: rtl/c17_bist_ctrl.sv
// c17_bist_ctrl: exhaustive 32-vector BIST of a c17 netlist against a built-in golden model, MISR signature.
// Latency: 32*(SETTLE+1) cycles from the first APPLY cycle to done.
// Backpressure: none; start is ignored while busy. C17_BIST_FAILLOG_EN adds a first-failing-vector log.
module c17_bist_ctrl #(
   parameter int unsigned SETTLE = 2   // cycles each vector is held before sampling, 1..15
) (
   input logic           clk,
   input logic           rst_n,
   c17_bist_ctrl_if.slave bus
);

   typedef enum logic [1:0] {IDLE, APPLY, SAMPLE, DONE} state_t;

   state_t     state_q, state_d;
   logic [4:0] vec_q;
   logic [3:0] cnt_q;
   logic [5:0] err_q;
   logic [7:0] sig_q;

   logic       run_clr;   // accepted start: clear all run state
   logic       cnt_inc;
   logic       cnt_clr;
   logic       smp;       // SAMPLE cycle: capture and compare responses at the closing edge
   logic       vec_inc;

   // Golden c17 evaluated on the vector currently driven.
   logic n1, n2, n3, n6, n7;
   logic n10, n11, n16, n19, g22, g23;
   logic miss;

   assign n1  = vec_q[0];
   assign n2  = vec_q[1];
   assign n3  = vec_q[2];
   assign n6  = vec_q[3];
   assign n7  = vec_q[4];
   assign n10 = ~(n1 & n3);
   assign n11 = ~(n3 & n6);
   assign n16 = ~(n2 & n11);
   assign n19 = ~(n11 & n7);
   assign g22 = ~(n10 & n16);
   assign g23 = ~(n16 & n19);
   assign miss = (bus.resp_n22 != g22) | (bus.resp_n23 != g23);

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;
   end

   // Next-state and datapath control.
   always_comb begin
      state_d = state_q;
      run_clr = 1'b0;
      cnt_inc = 1'b0;
      cnt_clr = 1'b0;
      smp     = 1'b0;
      vec_inc = 1'b0;
      case (state_q)
         IDLE, DONE: begin
            if (bus.start) begin
               state_d = APPLY;
               run_clr = 1'b1;
            end
         end
         APPLY: begin
            if (cnt_q == 4'(SETTLE - 1)) begin
               state_d = SAMPLE;
               cnt_clr = 1'b1;
            end else begin
               cnt_inc = 1'b1;
            end
         end
         SAMPLE: begin
            smp = 1'b1;
            if (vec_q == 5'd31) begin
               state_d = DONE;
            end else begin
               state_d = APPLY;
               vec_inc = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Vector, settle counter, error counter and MISR.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vec_q <= '0;
         cnt_q <= '0;
         err_q <= '0;
         sig_q <= '0;
      end else if (run_clr) begin
         vec_q <= '0;
         cnt_q <= '0;
         err_q <= '0;
         sig_q <= '0;
      end else begin
         if (cnt_clr)      cnt_q <= '0;
         else if (cnt_inc) cnt_q <= cnt_q + 4'd1;
         if (vec_inc)      vec_q <= vec_q + 5'd1;
         if (smp) begin
            sig_q <= {sig_q[6:0], sig_q[7] ^ sig_q[5] ^ sig_q[4] ^ sig_q[3]}
                     ^ {6'b0, bus.resp_n23, bus.resp_n22};
            if (miss) err_q <= err_q + 6'd1;
         end
      end
   end

`ifdef C17_BIST_FAILLOG_EN
   logic [4:0] ff_q;
   logic       ff_vld_q;

   // Latch the vector of the first mismatching sample of the run.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ff_q     <= '0;
         ff_vld_q <= 1'b0;
      end else if (run_clr) begin
         ff_q     <= '0;
         ff_vld_q <= 1'b0;
      end else if (smp && miss && !ff_vld_q) begin
         ff_q     <= vec_q;
         ff_vld_q <= 1'b1;
      end
   end

   assign bus.first_fail     = ff_q;
   assign bus.first_fail_vld = ff_vld_q;
`endif

   assign bus.vec       = vec_q;
   assign bus.busy      = (state_q == APPLY) || (state_q == SAMPLE);
   assign bus.done      = (state_q == DONE);
   assign bus.pass      = (state_q == DONE) && (err_q == 6'd0);
   assign bus.err_cnt   = err_q;
   assign bus.signature = sig_q;

endmodule

// File: tb/tb_c17_bist_ctrl.sv
// tb_c17_bist_ctrl: directed runs of the c17 BIST sequencer against a responder with selectable faults.
// Expected run results are queued at start and checked by a monitor when done rises.
// Runs: fault-free, N22 stuck-at-1, N23 inverted, start during run, reset during run.
module tb_c17_bist_ctrl;
   localparam int SETTLE = 2;
   localparam int RUN    = 32 * (SETTLE + 1);

   // Hand-derived c17 truth tables, bit v = response to vec v.
   // N22 = N1&N3 | N2&N11, N23 = N11&(N2|N7), N11 = ~(N3&N6).
   localparam logic [31:0] N22_TAB = 32'hACEC_ACEC;
   localparam logic [31:0] N23_TAB = 32'h0FFF_0CCC;

   typedef struct {
      logic [5:0] err;
      logic       pass;
      logic [7:0] sig;
      int         done_cyc;
      logic [4:0] ff;
      logic       ff_vld;
   } exp_t;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   int   mode  = 0;     // 0 good, 1 N22 stuck-at-1, 2 N23 inverted
   int   cyc   = 0;
   int   n_vec = 0;
   int   n_bad = 0;
   exp_t q[$];

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   c17_bist_ctrl_if bif();

   c17_bist_ctrl #(.SETTLE(SETTLE)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bif)
   );

   // Device-under-test responder with fault injection.
   always_comb begin
      bif.resp_n22 = N22_TAB[bif.vec];
      bif.resp_n23 = N23_TAB[bif.vec];
      if (mode == 1) bif.resp_n22 = 1'b1;
      if (mode == 2) bif.resp_n23 = ~N23_TAB[bif.vec];
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic logic [7:0] model_sig(input int m);
      logic [7:0] s;
      logic       r22, r23;
      s = 8'h00;
      for (int v = 0; v < 32; v++) begin
         r22 = N22_TAB[v];
         r23 = N23_TAB[v];
         if (m == 1) r22 = 1'b1;
         if (m == 2) r23 = ~r23;
         s = {s[6:0], s[7] ^ s[5] ^ s[4] ^ s[3]} ^ {6'b0, r23, r22};
      end
      return s;
   endfunction

   task automatic chk_all_zero(input string tag);
      chk({tag, "_vec"},  32'(bif.vec), 0);
      chk({tag, "_busy"}, 32'(bif.busy), 0);
      chk({tag, "_done"}, 32'(bif.done), 0);
      chk({tag, "_pass"}, 32'(bif.pass), 0);
      chk({tag, "_err"},  32'(bif.err_cnt), 0);
      chk({tag, "_sig"},  32'(bif.signature), 0);
`ifdef C17_BIST_FAILLOG_EN
      chk({tag, "_ff"},     32'(bif.first_fail), 0);
      chk({tag, "_ff_vld"}, 32'(bif.first_fail_vld), 0);
`endif
   endtask

   // Pulse start, queue the expected result of the run.
   task automatic start_run(input int m);
      exp_t e;
      mode = m;
      @(posedge clk); #1;
      bif.start = 1'b1;
      @(posedge clk); #1;
      bif.start = 1'b0;
      e.err      = (m == 0) ? 6'd0 : (m == 1) ? 6'd14 : 6'd32;
      e.pass     = (m == 0);
      e.sig      = model_sig(m);
      e.done_cyc = cyc + RUN;
      e.ff       = 5'd0;
      e.ff_vld   = (m != 0);
      q.push_back(e);
      chk("busy_after_start", 32'(bif.busy), 1);
   endtask

   task automatic wait_done();
      int n = 0;
      while (!bif.done && n < RUN + 20) begin
         @(posedge clk); #1;
         n++;
      end
      if (!bif.done) begin
         n_vec++;
         n_bad++;
         $display("FAIL done_timeout: done=%0b after %0d cycles, required 1", bif.done, n);
      end
      repeat (2) @(posedge clk);
      #1;
   endtask

   task automatic wait_vec(input logic [4:0] v);
      int n = 0;
      while (bif.vec != v && n < RUN) begin
         @(posedge clk); #1;
         n++;
      end
      if (bif.vec != v) begin
         n_vec++;
         n_bad++;
         $display("FAIL vec_timeout: vec=%0d, required %0d", bif.vec, v);
      end
   endtask

   // Monitor: compare each completed run against the head of the queue.
   initial begin
      logic done_prev;
      exp_t e;
      done_prev = 1'b0;
      forever begin
         @(negedge clk);
         if (bif.done && !done_prev) begin
            if (q.size() == 0) begin
               n_vec++;
               n_bad++;
               $display("FAIL unexpected_done: done=1 with no run outstanding");
            end else begin
               e = q.pop_front();
               chk("err_cnt",   32'(bif.err_cnt), 32'(e.err));
               chk("pass",      32'(bif.pass), 32'(e.pass));
               chk("signature", 32'(bif.signature), 32'(e.sig));
               chk("run_len",   32'(cyc), 32'(e.done_cyc));
               chk("busy_at_done", 32'(bif.busy), 0);
               chk("vec_at_done",  32'(bif.vec), 31);
`ifdef C17_BIST_FAILLOG_EN
               chk("first_fail",     32'(bif.first_fail), 32'(e.ff));
               chk("first_fail_vld", 32'(bif.first_fail_vld), 32'(e.ff_vld));
`endif
            end
         end
         done_prev = bif.done;
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad + 1);
      $fatal(1, "watchdog");
   end

   initial begin
      bif.start = 1'b0;
      #12;
      chk_all_zero("reset");
      @(posedge clk); #1;
      rst_n = 1'b1;

      // Fault-free, N22 stuck-at-1, N23 inverted.
      start_run(0);
      wait_done();
      chk("pass_held_in_done", 32'(bif.pass), 1);
      start_run(1);
      wait_done();
      chk("pass_low_on_fail", 32'(bif.pass), 0);
      start_run(2);
      wait_done();

      // Second start during a run is ignored.
      start_run(0);
      wait_vec(5'd5);
      bif.start = 1'b1;
      @(posedge clk); #1;
      bif.start = 1'b0;
      chk("busy_after_ignored_start", 32'(bif.busy), 1);
      wait_done();

      // Reset mid-run abandons it; outputs clear without a clock edge.
      start_run(1);
      wait_vec(5'd10);
      q.delete();
      #2;
      rst_n = 1'b0;
      #1;
      chk_all_zero("midrun_reset");
      @(posedge clk); #1;
      rst_n = 1'b1;
      start_run(0);
      wait_done();

      chk("queue_empty", 32'(q.size()), 0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end
endmodule
